exe_stage: RTL and testbench

Execute stage of the 5-stage MIPS32 pipeline, directly downstream of the decode stage. Registers the decoded micro-op (alutype/aluop/src1/src2/wa/wreg/mreg/din/whilo) and computes the ALU or effective-address result. Runs signed MULT as an iterative 32-cycle shift-add engine and holds the HI/LO pair. Stalls decode while busy and presents a registered EX/MEM bundle to the memory stage.

---
 rtl/mips_defs.sv | 58 +++++
 rtl/exe_stage_mult.sv | 80 ++++++++
 rtl/exe_stage.sv | 131 +++++++++++++
 tb/tb_exe_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS32 pipeline definitions: operand widths, ALU type/op encodings, EX/MEM bundle.
package mips_defs;

    localparam int unsigned REG_W       = 32;
    localparam int unsigned RA_W        = 5;
    localparam int unsigned HILO_W      = 64;
    localparam int unsigned ALUOP_W     = 8;
    localparam int unsigned ALUTYPE_W   = 3;
    localparam int unsigned MULT_CYCLES = 32;
    localparam int unsigned MCNT_W      = 6;

    localparam logic [ALUTYPE_W-1:0] ALUTYPE_NONE  = 3'b000;
    localparam logic [ALUTYPE_W-1:0] ALUTYPE_ARITH = 3'b001;
    localparam logic [ALUTYPE_W-1:0] ALUTYPE_LOGIC = 3'b010;
    localparam logic [ALUTYPE_W-1:0] ALUTYPE_MOVE  = 3'b011;
    localparam logic [ALUTYPE_W-1:0] ALUTYPE_SHIFT = 3'b100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 8'h18;
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU  = 8'h1B;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 8'h26;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 8'h1C;
    localparam logic [ALUOP_W-1:0] ALUOP_MULT  = 8'h14;
    localparam logic [ALUOP_W-1:0] ALUOP_MFHI  = 8'h0C;
    localparam logic [ALUOP_W-1:0] ALUOP_MFLO  = 8'h0D;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL   = 8'h11;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 8'h1D;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 8'h05;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDIU = 8'h19;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTIU = 8'h27;
    localparam logic [ALUOP_W-1:0] ALUOP_LB    = 8'h90;
    localparam logic [ALUOP_W-1:0] ALUOP_LW    = 8'h92;
    localparam logic [ALUOP_W-1:0] ALUOP_SB    = 8'h98;
    localparam logic [ALUOP_W-1:0] ALUOP_SW    = 8'h9A;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_BUSY = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_e;

    typedef struct packed {
        logic                valid;
        logic [ALUOP_W-1:0]  aluop;
        logic [RA_W-1:0]     wa;
        logic                wreg;
        logic                mreg;
        logic [REG_W-1:0]    wd;
        logic [REG_W-1:0]    din;
        logic                whilo;
        logic [HILO_W-1:0]   hilo;
    } exmem_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
    function automatic logic [REG_W-1:0] abs_val(input logic [REG_W-1:0] x);
        return x[REG_W-1] ? REG_W'(-x) : x;
    endfunction

endpackage

// File: rtl/exe_stage_mult.sv
// mult_iter: iterative signed shift-add multiplier, one multiplier bit per cycle.
module mult_iter
    import mips_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [REG_W-1:0]  a_i,
    input  logic [REG_W-1:0]  b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [HILO_W-1:0] product_o
);

    mult_state_e         state_q, state_d;
    logic [MCNT_W-1:0]   cnt_q, cnt_d;
    logic [HILO_W-1:0]   mcand_q, mcand_d;
    logic [HILO_W-1:0]   acc_q, acc_d;
    logic [REG_W-1:0]    mplier_q, mplier_d;
    logic                sign_q, sign_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MULT_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MULT_IDLE: if (start_i) state_d = MULT_BUSY;
            MULT_BUSY: if (cnt_q == MCNT_W'(MULT_CYCLES - 1)) state_d = MULT_DONE;
            MULT_DONE: state_d = MULT_IDLE;
            default:   state_d = MULT_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != MULT_IDLE);
        done_o    = (state_q == MULT_DONE);
        product_o = sign_q ? HILO_W'(-acc_q) : acc_q;
    end

    // Operate on magnitudes; the sign is reapplied once the accumulation finishes.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        if (state_q == MULT_IDLE && start_i) begin
            mcand_d  = HILO_W'(abs_val(a_i));
            mplier_d = abs_val(b_i);
            acc_d    = '0;
            cnt_d    = '0;
            sign_d   = a_i[REG_W-1] ^ b_i[REG_W-1];
        end else if (state_q == MULT_BUSY) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + MCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// MIPS32 execute stage: ALU, HI/LO and EX/MEM register. MULT_FAST_EN selects a
// single-cycle combinational MULT instead of the iterative mult_iter engine.
module exe_stage
    import mips_defs::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [ALUTYPE_W-1:0]  id_alutype_i,
    input  logic [ALUOP_W-1:0]    id_aluop_i,
    input  logic [REG_W-1:0]      id_src1_i,
    input  logic [REG_W-1:0]      id_src2_i,
    input  logic [RA_W-1:0]       id_wa_i,
    input  logic                  id_wreg_i,
    input  logic                  id_mreg_i,
    input  logic                  id_whilo_i,
    input  logic [REG_W-1:0]      id_din_i,
    output logic                  stall_o,
    output logic                  exe_valid_o,
    output logic [ALUOP_W-1:0]    exe_aluop_o,
    output logic [RA_W-1:0]       exe_wa_o,
    output logic                  exe_wreg_o,
    output logic                  exe_mreg_o,
    output logic [REG_W-1:0]      exe_wd_o,
    output logic [REG_W-1:0]      exe_din_o,
    output logic                  exe_whilo_o,
    output logic [HILO_W-1:0]     exe_hilo_o
);

    exmem_t              bundle_q, bundle_d;
    logic [HILO_W-1:0]   hilo_q, hilo_d;
    logic                accept_c;
    logic                is_mult_c;
    logic                mult_done_c;
    logic [HILO_W-1:0]   mult_prod_c;
    logic [REG_W-1:0]    alu_res_c;
    logic                unused_alutype;

    // The result select is fully determined by aluop; alutype is carried for decode symmetry.
    assign unused_alutype = ^id_alutype_i;
    assign is_mult_c      = (id_aluop_i == ALUOP_MULT);

`ifdef MULT_FAST_EN
    logic signed [HILO_W-1:0] op_a_c, op_b_c;

    assign op_a_c      = HILO_W'($signed(id_src1_i));
    assign op_b_c      = HILO_W'($signed(id_src2_i));
    assign stall_o     = 1'b0;
    assign accept_c    = id_valid_i;
    assign mult_done_c = accept_c & is_mult_c;
    assign mult_prod_c = HILO_W'(op_a_c * op_b_c);
`else
    logic mult_busy;

    assign stall_o  = mult_busy;
    assign accept_c = id_valid_i & ~mult_busy;

    mult_iter u_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept_c & is_mult_c),
        .a_i       (id_src1_i),
        .b_i       (id_src2_i),
        .busy_o    (mult_busy),
        .done_o    (mult_done_c),
        .product_o (mult_prod_c)
    );
`endif

    always_comb begin
        alu_res_c = '0;
        case (id_aluop_i)
            ALUOP_ADD, ALUOP_ADDIU,
            ALUOP_LB, ALUOP_LW,
            ALUOP_SB, ALUOP_SW: alu_res_c = id_src1_i + id_src2_i;
            ALUOP_SUBU:         alu_res_c = id_src1_i - id_src2_i;
            ALUOP_SLT:          alu_res_c = ($signed(id_src1_i) < $signed(id_src2_i)) ? REG_W'(1) : '0;
            ALUOP_SLTIU:        alu_res_c = (id_src1_i < id_src2_i) ? REG_W'(1) : '0;
            ALUOP_AND:          alu_res_c = id_src1_i & id_src2_i;
            ALUOP_ORI:          alu_res_c = id_src1_i | id_src2_i;
            ALUOP_LUI:          alu_res_c = id_src2_i;
            ALUOP_SLL:          alu_res_c = id_src2_i << id_src1_i[4:0];
            ALUOP_MFHI:         alu_res_c = hilo_q[HILO_W-1 -: REG_W];
            ALUOP_MFLO:         alu_res_c = hilo_q[REG_W-1:0];
            default:            alu_res_c = '0;
        endcase
    end

    // A finishing MULT never coincides with an accept: decode is stalled while it runs.
    always_comb begin
        bundle_d = '0;
        hilo_d   = hilo_q;
        if (mult_done_c) begin
            bundle_d.valid = 1'b1;
            bundle_d.aluop = ALUOP_MULT;
            bundle_d.whilo = 1'b1;
            bundle_d.hilo  = mult_prod_c;
            hilo_d         = mult_prod_c;
        end else if (accept_c && !is_mult_c) begin
            bundle_d.valid = 1'b1;
            bundle_d.aluop = id_aluop_i;
            bundle_d.wa    = id_wa_i;
            bundle_d.wreg  = id_wreg_i;
            bundle_d.mreg  = id_mreg_i;
            bundle_d.wd    = alu_res_c;
            bundle_d.din   = id_din_i;
            bundle_d.whilo = id_whilo_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
            hilo_q   <= '0;
        end else begin
            bundle_q <= bundle_d;
            hilo_q   <= hilo_d;
        end
    end

    assign exe_valid_o = bundle_q.valid;
    assign exe_aluop_o = bundle_q.aluop;
    assign exe_wa_o    = bundle_q.wa;
    assign exe_wreg_o  = bundle_q.wreg;
    assign exe_mreg_o  = bundle_q.mreg;
    assign exe_wd_o    = bundle_q.wd;
    assign exe_din_o   = bundle_q.din;
    assign exe_whilo_o = bundle_q.whilo;
    assign exe_hilo_o  = bundle_q.hilo;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage (default build, iterative MULT).
module tb_exe_stage;

    localparam logic [7:0] OP_ADD = 8'h18, OP_SUBU = 8'h1B, OP_SLT = 8'h26, OP_AND = 8'h1C;
    localparam logic [7:0] OP_MULT = 8'h14, OP_MFHI = 8'h0C, OP_MFLO = 8'h0D, OP_SLL = 8'h11;
    localparam logic [7:0] OP_ORI = 8'h1D, OP_LUI = 8'h05, OP_ADDIU = 8'h19, OP_SLTIU = 8'h27;
    localparam logic [7:0] OP_LW = 8'h92, OP_SB = 8'h98, OP_SW = 8'h9A;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [2:0]  id_alutype_i;
    logic [7:0]  id_aluop_i;
    logic [31:0] id_src1_i, id_src2_i, id_din_i;
    logic [4:0]  id_wa_i;
    logic        id_wreg_i, id_mreg_i, id_whilo_i;
    logic        stall_o, exe_valid_o, exe_wreg_o, exe_mreg_o, exe_whilo_o;
    logic [7:0]  exe_aluop_o;
    logic [4:0]  exe_wa_o;
    logic [31:0] exe_wd_o, exe_din_o;
    logic [63:0] exe_hilo_o;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_alutype_i(id_alutype_i), .id_aluop_i(id_aluop_i),
        .id_src1_i(id_src1_i), .id_src2_i(id_src2_i), .id_wa_i(id_wa_i),
        .id_wreg_i(id_wreg_i), .id_mreg_i(id_mreg_i), .id_whilo_i(id_whilo_i),
        .id_din_i(id_din_i), .stall_o(stall_o), .exe_valid_o(exe_valid_o),
        .exe_aluop_o(exe_aluop_o), .exe_wa_o(exe_wa_o), .exe_wreg_o(exe_wreg_o),
        .exe_mreg_o(exe_mreg_o), .exe_wd_o(exe_wd_o), .exe_din_o(exe_din_o),
        .exe_whilo_o(exe_whilo_o), .exe_hilo_o(exe_hilo_o)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] s1, s2, din;
        logic [4:0]  wa;
        logic        wreg, mreg;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic [7:0]  aluop;
        logic [4:0]  wa;
        logic        wreg, mreg, whilo;
        logic [31:0] wd, din;
        logic [63:0] hilo;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, stall_cnt = 0, ori_seen = 0, ori_cyc = -1, mult_cyc = -1;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] op, input logic [4:0] wa, input logic wreg,
                                input logic mreg, input logic [31:0] wd, input logic [31:0] din);
        exp_t e;
        e.aluop = op; e.wa = wa; e.wreg = wreg; e.mreg = mreg; e.whilo = 1'b0;
        e.wd = wd; e.din = din; e.hilo = '0;
        return e;
    endfunction

    function automatic exp_t mkm(input logic [63:0] prod);
        exp_t e;
        e.aluop = OP_MULT; e.wa = '0; e.wreg = 1'b0; e.mreg = 1'b0; e.whilo = 1'b1;
        e.wd = '0; e.din = '0; e.hilo = prod;
        return e;
    endfunction

    // Scoreboard monitor: compare every emitted bundle, require all-zero bubbles.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && !rst) begin
            if (stall_o) stall_cnt++;
            if (exe_valid_o) begin
                if (exe_aluop_o == OP_ORI) begin ori_seen++; ori_cyc = cyc; end
                if (exe_aluop_o == OP_MULT) mult_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_bundle", 64'(exe_aluop_o), 64'h1ff);
                end else begin
                    e = sb.pop_front();
                    chk("aluop", 64'(exe_aluop_o), 64'(e.aluop));
                    chk($sformatf("wd op%0h", e.aluop), 64'(exe_wd_o), 64'(e.wd));
                    chk($sformatf("din op%0h", e.aluop), 64'(exe_din_o), 64'(e.din));
                    chk($sformatf("ctl op%0h", e.aluop),
                        64'({exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o}),
                        64'({e.wa, e.wreg, e.mreg, e.whilo}));
                    chk($sformatf("hilo op%0h", e.aluop), exe_hilo_o, e.hilo);
                end
            end else begin
                chk("bubble_zero", 64'(|{exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o,
                                         exe_wd_o, exe_din_o, exe_whilo_o, exe_hilo_o}), 64'h0);
            end
        end
    end

    // Drive a micro-op and hold it valid until the stage takes it.
    task automatic issue(input logic [7:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] din, input logic [4:0] wa, input logic wreg,
                         input logic mreg, output int acc_cyc);
        bit free;
        int n;
        n = 0;
        id_valid_i = 1'b1; id_aluop_i = op; id_src1_i = s1; id_src2_i = s2; id_din_i = din;
        id_wa_i = wa; id_wreg_i = wreg; id_mreg_i = mreg; id_whilo_i = (op == OP_MULT);
        id_alutype_i = 3'b001;
        do begin
            free = !stall_o;
            @(posedge clk); #1;
            n++;
        end while (!free && n < 200);
        if (!free) chk("accept_timeout", 64'h0, 64'h1);
        acc_cyc = cyc;
        id_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 64'(sb.size()), 64'h0);
    endtask

    task automatic mult_then_read(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prod);
        int t;
        sb.push_back(mkm(prod));
        issue(OP_MULT, a, b, 32'h0, 5'd0, 1'b0, 1'b0, t);
        sb.push_back(mk(OP_MFHI, 5'd2, 1'b1, 1'b0, prod[63:32], 32'h0));
        issue(OP_MFHI, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, t);
        sb.push_back(mk(OP_MFLO, 5'd3, 1'b1, 1'b0, prod[31:0], 32'h0));
        issue(OP_MFLO, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, t);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[14];
        int          a, m;
        logic [31:0] r1, r2;
        longint      p;

        tbl[0]  = '{OP_ADD,   32'd3,         32'd4,         32'h11111111, 5'd1,  1'b1, 1'b0, 32'd7};
        tbl[1]  = '{OP_SUBU,  32'd5,         32'd7,         32'h0,        5'd2,  1'b1, 1'b0, 32'hFFFFFFFE};
        tbl[2]  = '{OP_SLT,   32'hFFFFFFFF,  32'd1,         32'h0,        5'd3,  1'b1, 1'b0, 32'd1};
        tbl[3]  = '{OP_SLTIU, 32'hFFFFFFFF,  32'd1,         32'h0,        5'd4,  1'b1, 1'b0, 32'd0};
        tbl[4]  = '{OP_SLL,   32'd4,         32'h1,         32'h0,        5'd5,  1'b1, 1'b0, 32'h10};
        tbl[5]  = '{OP_AND,   32'hF0F000FF,  32'h0FF00F0F,  32'h0,        5'd6,  1'b1, 1'b0, 32'h00F0000F};
        tbl[6]  = '{OP_ORI,   32'h12340000,  32'h0000ABCD,  32'h0,        5'd7,  1'b1, 1'b0, 32'h1234ABCD};
        tbl[7]  = '{OP_LUI,   32'h0,         32'hBEEF0000,  32'h0,        5'd8,  1'b1, 1'b0, 32'hBEEF0000};
        tbl[8]  = '{OP_ADDIU, 32'hFFFFFFFF,  32'd1,         32'h0,        5'd9,  1'b1, 1'b0, 32'h0};
        tbl[9]  = '{OP_LW,    32'h100,       32'h8,         32'h0,        5'd10, 1'b1, 1'b1, 32'h108};
        tbl[10] = '{OP_SW,    32'h1000,      32'hFFFFFFFC,  32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 32'h00000FFC};
        tbl[11] = '{8'h3F,    32'd1,         32'd2,         32'h0,        5'd11, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{OP_SB,    32'h2000,      32'd3,         32'h55,       5'd0,  1'b0, 1'b0, 32'h2003};
        tbl[13] = '{OP_SLT,   32'd1,         32'hFFFFFFFF,  32'h0,        5'd12, 1'b1, 1'b0, 32'd0};

        rst = 1'b1; id_valid_i = 1'b0; id_alutype_i = '0; id_aluop_i = '0;
        id_src1_i = '0; id_src2_i = '0; id_din_i = '0; id_wa_i = '0;
        id_wreg_i = 1'b0; id_mreg_i = 1'b0; id_whilo_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(exe_valid_o), 64'h0);
        chk("rst_stall", 64'(stall_o), 64'h0);
        chk("rst_wd", 64'(exe_wd_o), 64'h0);
        chk("rst_hilo", exe_hilo_o, 64'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            sb.push_back(mk(tbl[i].op, tbl[i].wa, tbl[i].wreg, tbl[i].mreg, tbl[i].wd, tbl[i].din));
            issue(tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].din, tbl[i].wa, tbl[i].wreg, tbl[i].mreg, a);
        end
        drain();

        // Negative by positive: timing of stall and result emission.
        sb.push_back(mkm(64'hFFFFFFFF_FFFFFFEB));
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'h0, 5'd0, 1'b0, 1'b0, a);
        stall_cnt = 0;
        drain();
        chk("mult_stall_cycles", 64'(stall_cnt), 64'd33);
        chk("mult_latency", 64'(mult_cyc - a), 64'd33);
        sb.push_back(mk(OP_MFLO, 5'd3, 1'b1, 1'b0, 32'hFFFFFFEB, 32'h0));
        issue(OP_MFLO, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, a);
        sb.push_back(mk(OP_MFHI, 5'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0));
        issue(OP_MFHI, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, a);
        drain();

        mult_then_read(32'h80000000, 32'h80000000, 64'h40000000_00000000);
        for (int k = 0; k < 2; k++) begin
            r1 = $urandom;
            r2 = $urandom;
            p  = longint'(int'(r1)) * longint'(int'(r2));
            mult_then_read(r1, r2, 64'(p));
        end

        // ADD, MULT, ORI back to back with valid held through the stall.
        ori_seen = 0;
        sb.push_back(mk(OP_ADD, 5'd1, 1'b1, 1'b0, 32'd11, 32'h0));
        issue(OP_ADD, 32'd5, 32'd6, 32'h0, 5'd1, 1'b1, 1'b0, a);
        sb.push_back(mkm(64'd30));
        issue(OP_MULT, 32'd5, 32'd6, 32'h0, 5'd0, 1'b0, 1'b0, m);
        sb.push_back(mk(OP_ORI, 5'd4, 1'b1, 1'b0, 32'h0000F0F3, 32'h0));
        issue(OP_ORI, 32'h0000F0F0, 32'h3, 32'h0, 5'd4, 1'b1, 1'b0, a);
        drain();
        chk("ori_once", 64'(ori_seen), 64'd1);
        chk("ori_latency", 64'(ori_cyc - m), 64'd34);

        // Reset in the middle of a MULT: result discarded, HI/LO cleared.
        sb.push_back(mkm(64'd42));
        issue(OP_MULT, 32'd6, 32'd7, 32'h0, 5'd0, 1'b0, 1'b0, a);
        repeat (10) begin @(posedge clk); #1; end
        chk("busy_before_rst", 64'(stall_o), 64'h1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(exe_valid_o), 64'h0);
        chk("midrst_stall", 64'(stall_o), 64'h0);
        chk("midrst_hilo", exe_hilo_o, 64'h0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back(mk(OP_MFLO, 5'd3, 1'b1, 1'b0, 32'h0, 32'h0));
        issue(OP_MFLO, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, a);
        sb.push_back(mk(OP_MFHI, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0));
        issue(OP_MFHI, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, a);
        sb.push_back(mk(OP_ADD, 5'd1, 1'b1, 1'b0, 32'd7, 32'h0));
        issue(OP_ADD, 32'd3, 32'd4, 32'h0, 5'd1, 1'b1, 1'b0, a);
        drain();
        repeat (3) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
